// File: rtl/openddr_pkg.sv
// Shared definitions for the openddr controller blocks.
//   apb_mst_state_t : APB initiator FSM states
//   APB_ADDR_W/DATA_W : default APB configuration-port widths
package openddr_pkg;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

endpackage

// File: rtl/openddr_apb_master.sv
// APB3 initiator: converts a valid/ready command stream into single APB
// read/write transfers and returns a registered response with error and
// wait-state timeout status.
//   clk, rst                     : clock, synchronous active-high reset
//   cmd_valid/ready/wr/addr/wdata: command channel (one outstanding)
//   rsp_valid/ready/rdata/err/timeout : response channel
//   psel/penable/pwr/paddr/pwdata, prdata/pready/pslverr : APB3 port
module openddr_apb_master
  import openddr_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwr,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_mst_state_t   state;
  logic [CNT_W-1:0] wait_cnt;

  // Handshake and APB strobes decode from the state register only, so no
  // input reaches an output combinationally.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pwr         <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // Bus fields are latched once and stay frozen through ACCESS.
            paddr    <= {cmd_addr[ADDR_W-1:2], 2'b00};
            pwr      <= cmd_wr;
            pwdata   <= cmd_wdata;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          // Completion wins over timeout when both land in the same cycle.
          if (pready) begin
            rsp_rdata   <= pwr ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_openddr_apb_master.sv
// Self-checking bench for openddr_apb_master with a behavioural APB slave
// stub and a queue-based response scoreboard.
module tb_openddr_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwr, pready, pslverr;
  logic [9:0]  paddr;
  logic [31:0] pwdata, prdata;

  always #5 clk = ~clk;

  openddr_apb_master #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwr(pwr), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Slave stub: pready on ACCESS cycle sl_delay (0 = never), fixed read
  // data at 0x008 and 0x030, a small write-back memory elsewhere.
  int          sl_delay = 2;
  logic        sl_err = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] wmem [256];

  always @(posedge clk)
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  always @(posedge clk)
    if (psel && penable && pready && pwr) wmem[paddr[9:2]] <= pwdata;

  assign pready  = psel && penable && (sl_delay != 0) && (acc_cnt + 1 == sl_delay);
  assign pslverr = pready && sl_err;
  assign prdata  = (paddr == 10'h008) ? 32'h12345678 :
                   (paddr == 10'h030) ? 32'hDEADBEEF : wmem[paddr[9:2]];

  // Bus monitor: ACCESS-cycle count and bus-field stability while psel.
  int          acc_seen = 0, stab_cnt = 0, stab_bad = 0;
  logic        mon_on = 1'b0;
  logic [9:0]  chk_addr = '0;
  logic [31:0] chk_wdata = '0;

  always @(negedge clk) begin
    if (psel && penable) acc_seen++;
    if (mon_on && psel) begin
      stab_cnt++;
      if (!pwr || paddr !== chk_addr || pwdata !== chk_wdata) stab_bad++;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;

  // Issue one command and wait for its response; inputs change and
  // outputs are sampled on the falling edge. lat counts cycles from the
  // accepting edge to the first cycle with rsp_valid.
  task automatic run_cmd(input logic wr, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic hold,
                         output logic [31:0] rd, output logic err,
                         output logic to, output int lat, output logic ok);
    int g;
    ok = 1'b1;
    @(negedge clk);
    cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
    rsp_ready = !hold;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!rsp_valid) ok = 1'b0;
    rd = rsp_rdata; err = rsp_err; to = rsp_timeout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwr} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 1000000",
               {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwr});
    end
    n_cmp++;
    if (rsp_rdata !== 32'h0 || paddr !== 10'h0 || pwdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: rdata=%h paddr=%h pwdata=%h want all 0", rsp_rdata, paddr, pwdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_config_read();
    logic [31:0] rd; logic err, to, ok; int lat; exp_t e;
    sl_delay = 2; sl_err = 1'b0;
    sb.push_back('{32'h12345678, 1'b0, 1'b0});
    run_cmd(1'b0, 10'h008, 32'h0, 1'b0, rd, err, to, lat, ok);
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || lat != 4) begin
      n_bad++; $display("FAIL cfg_rd_latency: ok=%0b lat=%0d want ok=1 lat=4", ok, lat);
    end
    n_cmp++;
    if ({rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL cfg_rd_rsp: got %h/%b/%b want %h/%b/%b", rd, err, to, e.rdata, e.err, e.to);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err, to, ok; int lat; exp_t e;
    sl_delay = 2; sl_err = 1'b0;
    chk_addr = 10'h020; chk_wdata = 32'h000000A5; stab_cnt = 0; stab_bad = 0; mon_on = 1'b1;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    run_cmd(1'b1, 10'h020, 32'h000000A5, 1'b0, rd, err, to, lat, ok);
    mon_on = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || {rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL wr_rsp: ok=%0b got %h/%b/%b want %h/%b/%b", ok, rd, err, to, e.rdata, e.err, e.to);
    end
    n_cmp++;
    if (stab_cnt != 3 || stab_bad != 0) begin
      n_bad++; $display("FAIL wr_bus_stable: psel_cycles=%0d bad=%0d want 3/0", stab_cnt, stab_bad);
    end
    sb.push_back('{32'h000000A5, 1'b0, 1'b0});
    run_cmd(1'b0, 10'h020, 32'h0, 1'b0, rd, err, to, lat, ok);
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || {rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL rd_back: ok=%0b got %h/%b/%b want %h/%b/%b", ok, rd, err, to, e.rdata, e.err, e.to);
    end
  endtask

  task automatic test_unaligned();
    logic [31:0] rd; logic err, to, ok; int lat; exp_t e;
    sl_delay = 2; sl_err = 1'b0;
    chk_addr = 10'h020; chk_wdata = 32'h00005A5A; stab_cnt = 0; stab_bad = 0; mon_on = 1'b1;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    run_cmd(1'b1, 10'h023, 32'h00005A5A, 1'b0, rd, err, to, lat, ok);
    mon_on = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || stab_cnt != 3 || stab_bad != 0) begin
      n_bad++; $display("FAIL unaligned_paddr: ok=%0b psel_cycles=%0d bad=%0d want 1/3/0", ok, stab_cnt, stab_bad);
    end
    n_cmp++;
    if (wmem[8] !== 32'h00005A5A || {rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL unaligned_wr: mem=%h rsp=%h/%b/%b want 00005a5a/%h/%b/%b", wmem[8], rd, err, to, e.rdata, e.err, e.to);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic err, to, ok; int lat; exp_t e;
    sl_delay = 0; sl_err = 1'b0; acc_seen = 0;
    sb.push_back('{32'h0, 1'b1, 1'b1});
    run_cmd(1'b0, 10'h008, 32'h0, 1'b0, rd, err, to, lat, ok);
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || acc_seen != 16 || lat != 18) begin
      n_bad++; $display("FAIL timeout_len: ok=%0b access=%0d lat=%0d want 1/16/18", ok, acc_seen, lat);
    end
    n_cmp++;
    if ({rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL timeout_rsp: got %h/%b/%b want %h/%b/%b", rd, err, to, e.rdata, e.err, e.to);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic err, to, ok; int lat; exp_t e;
    sl_delay = 3; sl_err = 1'b1;
    sb.push_back('{32'hDEADBEEF, 1'b1, 1'b0});
    run_cmd(1'b0, 10'h030, 32'h0, 1'b0, rd, err, to, lat, ok);
    sl_err = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || lat != 5 || {rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL slverr_rsp: ok=%0b lat=%0d got %h/%b/%b want lat=5 %h/%b/%b", ok, lat, rd, err, to, e.rdata, e.err, e.to);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic err, to, ok; int lat; exp_t e;
    sl_delay = 2; sl_err = 1'b0;
    sb.push_back('{32'h12345678, 1'b0, 1'b0});
    run_cmd(1'b0, 10'h008, 32'h0, 1'b1, rd, err, to, lat, ok);
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || {rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL bp_rsp: ok=%0b got %h/%b/%b want %h/%b/%b", ok, rd, err, to, e.rdata, e.err, e.to);
    end
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h040; cmd_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1 ||
          {rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: rdy=%b psel=%b vld=%b rsp=%h/%b/%b want 0/0/1 %h/%b/%b", i,
                 cmd_ready, psel, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: vld=%b rdy=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err, to, ok; int lat, g; exp_t e;
    sl_delay = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h050; cmd_wdata = 32'h77;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    g = 0;
    while (!penable && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001 || paddr !== 10'h0 || pwdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid: sel/en/vld/rdy=%b paddr=%h pwdata=%h want 0001/0/0",
                        {psel, penable, rsp_valid, cmd_ready}, paddr, pwdata);
    end
    rst = 1'b0; sl_delay = 2;
    sb.push_back('{32'h12345678, 1'b0, 1'b0});
    run_cmd(1'b0, 10'h008, 32'h0, 1'b0, rd, err, to, lat, ok);
    e = sb.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || lat != 4 || {rd, err, to} !== {e.rdata, e.err, e.to}) begin
      n_bad++; $display("FAIL rst_recover: ok=%0b lat=%0d got %h/%b/%b want lat=4 %h/%b/%b", ok, lat, rd, err, to, e.rdata, e.err, e.to);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_config_read();
    test_write_read();
    test_unaligned();
    test_timeout();
    test_slverr();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
